// File: rtl/corr_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : corr_pkg
//  Brief   : Shared constants and state encodings for the correlator sweep
//            scheduler and its result-frame transmitter.
//  Rev     : 1.0  initial release
// ============================================================================
package corr_pkg;

    localparam logic [7:0] FRAME_HDR = 8'hA5;
    localparam int         FRAME_LEN = 5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_RUN    = 3'd2,
        S_SCAN   = 3'd3,
        S_NEXT   = 3'd4,
        S_REPORT = 3'd5,
        S_DONE   = 3'd6
    } sweep_state_t;

    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_SEND  = 2'd1,
        F_GUARD = 2'd2,
        F_DRAIN = 2'd3
    } frame_state_t;

endpackage
`default_nettype wire

// File: rtl/corr_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module  : corr_frame_tx
//  Brief   : Sends the 5-byte sweep result frame over the UART byte handshake.
//  Rev     : 1.0  initial release
// ============================================================================
module corr_frame_tx
    import corr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_go,
    input  logic [7:0] i_idx,
    input  logic [7:0] i_val,
    input  logic       i_flag,
    input  logic       i_tx_busy,
    output logic [7:0] o_tx_data,
    output logic       o_tx_start,
    output logic       o_fin
);

    frame_state_t r_state;
    frame_state_t w_next;
    logic [2:0]   r_k;
    logic [7:0]   r_tx_data;
    logic [7:0]   w_cur;
    logic [7:0]   w_chk;
    logic         w_last;

    assign w_chk  = i_idx ^ i_val ^ {7'b0, i_flag};
    assign w_last = (r_k == 3'(FRAME_LEN - 1));

    always_comb begin
        w_cur = w_chk;
        case (r_k)
            3'd0:    w_cur = FRAME_HDR;
            3'd1:    w_cur = i_idx;
            3'd2:    w_cur = i_val;
            3'd3:    w_cur = {7'b0, i_flag};
            default: w_cur = w_chk;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= F_IDLE;
        else     r_state <= w_next;
    end

    // The guard cycle after each strobe ignores tx_busy, which only rises a cycle later.
    always_comb begin
        w_next     = r_state;
        o_tx_start = 1'b0;
        o_fin      = 1'b0;
        case (r_state)
            F_IDLE:  if (i_go) w_next = F_SEND;
            F_SEND:  if (!i_tx_busy) begin
                         o_tx_start = 1'b1;
                         w_next     = F_GUARD;
                     end
            F_GUARD: w_next = w_last ? F_DRAIN : F_SEND;
            F_DRAIN: if (!i_tx_busy) begin
                         o_fin  = 1'b1;
                         w_next = F_IDLE;
                     end
            default: w_next = F_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k       <= 3'd0;
            r_tx_data <= 8'd0;
        end else begin
            if (r_state == F_IDLE && i_go)
                r_k <= 3'd0;
            else if (r_state == F_GUARD && !w_last)
                r_k <= r_k + 3'd1;
            if (o_tx_start)
                r_tx_data <= w_cur;
        end
    end

    // Data is live with the strobe and then held until the next one.
    assign o_tx_data = o_tx_start ? w_cur : r_tx_data;

endmodule
`default_nettype wire

// File: rtl/corr_sweep_sched.sv
`default_nettype none
// ============================================================================
//  Module  : corr_sweep_sched
//  Brief   : Sweeps code phase over PASSES passes of the lane bank, tracks the
//            best lane result and reports it as a 5-byte UART frame.
//  Rev     : 1.0  initial release
// ============================================================================
module corr_sweep_sched
    import corr_pkg::*;
#(
    parameter int LANES     = 8,
    parameter int RW        = 8,
    parameter int PW        = 16,
    parameter int PASS_STEP = 6144,
    parameter int PASSES    = 8,
    parameter int TIMEOUT   = 1 << 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [LANES-1:0]    i_lane_rdy,
    input  logic [LANES*RW-1:0] i_lane_result,
    output logic                o_lane_rst,
    output logic [PW-1:0]       o_phase_base,
    output logic [7:0]          o_tx_data,
    output logic                o_tx_start,
    input  logic                i_tx_busy,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_timeout_flag
);

    localparam int LW  = $clog2(LANES);
    localparam int PSW = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int TW  = $clog2(TIMEOUT + 1);

    sweep_state_t r_state;
    sweep_state_t w_next;

    logic             r_arm;
    logic [PSW-1:0]   r_pass;
    logic [LW-1:0]    r_lane;
    logic [TW-1:0]    r_tcnt;
    logic [LANES-1:0] r_rdy_seen;
    logic [RW-1:0]    r_cap [LANES];
    logic [RW-1:0]    r_best_val;
    logic [7:0]       r_best_idx;
    logic [PW-1:0]    r_phase;
    logic             r_tflag;

    logic       w_all_rdy;
    logic       w_tmo;
    logic       w_last_lane;
    logic       w_last_pass;
    logic       w_fin;
    logic       w_frame_go;
    logic [7:0] w_val_byte;

    // Lanes that become ready this very cycle count toward the all-ready exit.
    assign w_all_rdy   = &(r_rdy_seen | i_lane_rdy);
    assign w_tmo       = (r_tcnt == TW'(TIMEOUT - 1));
    assign w_last_lane = (r_lane == LW'(LANES - 1));
    assign w_last_pass = (r_pass == PSW'(PASSES - 1));
    assign w_frame_go  = (r_state == S_NEXT) && w_last_pass;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_next = S_ARM;
            S_ARM:    if (r_arm) w_next = S_RUN;
            S_RUN:    if (w_all_rdy || w_tmo) w_next = S_SCAN;
            S_SCAN:   if (w_last_lane) w_next = S_NEXT;
            S_NEXT:   w_next = w_last_pass ? S_REPORT : S_ARM;
            S_REPORT: if (w_fin) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_arm      <= 1'b0;
            r_pass     <= '0;
            r_lane     <= '0;
            r_tcnt     <= '0;
            r_rdy_seen <= '0;
            r_best_val <= '0;
            r_best_idx <= 8'd0;
            r_phase    <= '0;
            r_tflag    <= 1'b0;
            for (int j = 0; j < LANES; j++) r_cap[j] <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_arm      <= 1'b0;
                    r_pass     <= '0;
                    r_best_val <= '0;
                    r_best_idx <= 8'd0;
                    r_phase    <= '0;
                    r_tflag    <= 1'b0;
                end
                S_ARM: begin
                    r_arm      <= ~r_arm;
                    r_rdy_seen <= '0;
                    r_tcnt     <= '0;
                    r_lane     <= '0;
                end
                S_RUN: begin
                    r_tcnt <= r_tcnt + TW'(1);
                    for (int j = 0; j < LANES; j++) begin
                        if (i_lane_rdy[j] && !r_rdy_seen[j]) begin
                            r_rdy_seen[j] <= 1'b1;
                            r_cap[j]      <= i_lane_result[j*RW +: RW];
                        end
                    end
                    if (w_tmo && !w_all_rdy) r_tflag <= 1'b1;
                end
                S_SCAN: begin
                    if (r_rdy_seen[r_lane] && (r_cap[r_lane] > r_best_val)) begin
                        r_best_val <= r_cap[r_lane];
                        r_best_idx <= 8'(int'(r_pass) * LANES + int'(r_lane));
                    end
                    r_lane <= r_lane + LW'(1);
                end
                S_NEXT: if (!w_last_pass) begin
                    r_pass  <= r_pass + PSW'(1);
                    r_phase <= r_phase + PW'(PASS_STEP);
                end
                default: ;
            endcase
        end
    end

    generate
        if (RW >= 8) begin : g_val_wide
            assign w_val_byte = r_best_val[RW-1 -: 8];
        end else begin : g_val_narrow
            assign w_val_byte = {{(8-RW){1'b0}}, r_best_val};
        end
    endgenerate

    corr_frame_tx u_frame_tx (
        .clk        (clk),
        .rst        (rst),
        .i_go       (w_frame_go),
        .i_idx      (r_best_idx),
        .i_val      (w_val_byte),
        .i_flag     (r_tflag),
        .i_tx_busy  (i_tx_busy),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .o_fin      (w_fin)
    );

    assign o_lane_rst     = (r_state == S_ARM);
    assign o_busy         = (r_state != S_IDLE);
    assign o_done         = (r_state == S_DONE);
    assign o_phase_base   = r_phase;
    assign o_timeout_flag = r_tflag;

endmodule
`default_nettype wire

// File: tb/tb_corr_sweep_sched.sv
`default_nettype none
// ============================================================================
//  Module  : tb_corr_sweep_sched
//  Brief   : Self-checking bench for corr_sweep_sched (4 lanes, 2 passes).
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_corr_sweep_sched;

    localparam int LANES     = 4;
    localparam int RW        = 8;
    localparam int PW        = 16;
    localparam int PASS_STEP = 6144;
    localparam int PASSES    = 2;
    localparam int TIMEOUT   = 64;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [LANES-1:0]    lane_rdy;
    logic [LANES*RW-1:0] lane_result;
    logic                lane_rst;
    logic [PW-1:0]       phase_base;
    logic [7:0]          tx_data;
    logic                tx_start;
    logic                tx_busy;
    logic                busy;
    logic                done;
    logic                timeout_flag;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    bit         exp_flag;
    int         rx_count = 0;
    int         busy_len = 8;
    int         cyc = 0;
    bit         prev_start = 1'b0;

    bit [7:0] g_res[PASSES][LANES];
    int       g_dly[PASSES][LANES];
    int       g_xd;
    bit [7:0] g_xv;

    corr_sweep_sched #(
        .LANES(LANES), .RW(RW), .PW(PW), .PASS_STEP(PASS_STEP),
        .PASSES(PASSES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (start),
        .i_lane_rdy     (lane_rdy),
        .i_lane_result  (lane_result),
        .o_lane_rst     (lane_rst),
        .o_phase_base   (phase_base),
        .o_tx_data      (tx_data),
        .o_tx_start     (tx_start),
        .i_tx_busy      (tx_busy),
        .o_busy         (busy),
        .o_done         (done),
        .o_timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // UART stand-in: busy rises the cycle after a strobe and lasts busy_len cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1 && busy_len > 0) begin
                @(posedge clk); #1 tx_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // Scoreboard consumer: every transmitted byte is matched against the model.
    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_extra got=%02h expected=none", tx_data);
            end else begin
                exp_b = exp_q.pop_front();
                if (tx_data !== exp_b) begin
                    errors++;
                    $display("FAIL tx_byte got=%02h expected=%02h", tx_data, exp_b);
                end
            end
            rx_count++;
            checks++;
            if (prev_start) begin
                errors++;
                $display("FAIL tx_start_consecutive got=1 expected=0");
            end
            checks++;
            if (tx_busy !== 1'b0) begin
                errors++;
                $display("FAIL tx_start_while_busy busy=%b expected=0", tx_busy);
            end
        end
        prev_start = (tx_start === 1'b1);
    end

    task automatic push_expected();
        logic [7:0] bv, bi;
        bit fl;
        bv = 8'd0; bi = 8'd0; fl = 1'b0;
        for (int p = 0; p < PASSES; p++)
            for (int j = 0; j < LANES; j++) begin
                if (g_dly[p][j] < 0) fl = 1'b1;
                else if (g_res[p][j] > bv) begin
                    bv = g_res[p][j];
                    bi = 8'(p * LANES + j);
                end
            end
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(bi);
        exp_q.push_back(bv);
        exp_q.push_back({7'b0, fl});
        exp_q.push_back(bi ^ bv ^ {7'b0, fl});
        exp_flag = fl;
    endtask

    task automatic run_sweep(input string name, input int blen, input bit mid_start,
                             input int abort_after);
        int k, tf_prev, rlen, maxd, maxt, rx0;
        bit all;
        tf_prev = 0; rlen = 0;
        push_expected();
        busy_len = blen;
        rx0 = rx_count;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL %s_busy_rise got=%b expected=1", name, busy);
        end
        for (int p = 0; p < PASSES; p++) begin
            k = 0;
            while (lane_rst !== 1'b1 && k < 300) begin @(negedge clk); k++; end
            checks++;
            if (lane_rst !== 1'b1) begin
                errors++; $display("FAIL %s_arm_wait got=%b expected=1", name, lane_rst);
            end
            if (p > 0) begin
                checks++;
                if (cyc - tf_prev != rlen + LANES + 1) begin
                    errors++;
                    $display("FAIL %s_pass_gap got=%0d expected=%0d", name, cyc - tf_prev, rlen + LANES + 1);
                end
            end
            checks++;
            if (phase_base !== PW'(p * PASS_STEP)) begin
                errors++;
                $display("FAIL %s_phase p%0d got=%0d expected=%0d", name, p, phase_base, p * PASS_STEP);
            end
            k = 0;
            while (lane_rst === 1'b1 && k < 10) begin @(negedge clk); k++; end
            checks++;
            if (k != 2) begin
                errors++; $display("FAIL %s_lane_rst_len got=%0d expected=2", name, k);
            end
            tf_prev = cyc;
            maxd = 0; all = 1'b1;
            for (int j = 0; j < LANES; j++) begin
                if (g_dly[p][j] < 0) all = 1'b0;
                else if (g_dly[p][j] > maxd) maxd = g_dly[p][j];
            end
            maxt = (p == 0 && g_xd > maxd) ? g_xd : maxd;
            rlen = all ? maxd + 1 : TIMEOUT;
            for (int t = 0; t <= maxt; t++) begin
                lane_rdy = '0;
                lane_result = {LANES{8'hEE}};
                for (int j = 0; j < LANES; j++)
                    if (g_dly[p][j] == t) begin
                        lane_rdy[j] = 1'b1;
                        lane_result[j*RW +: RW] = g_res[p][j];
                    end
                if (p == 0 && t == g_xd) begin
                    lane_rdy[0] = 1'b1;
                    lane_result[0 +: RW] = g_xv;
                end
                if (mid_start && p == 1 && t == 0) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            lane_rdy = '0;
        end
        if (abort_after > 0) begin
            k = 0;
            while (rx_count < rx0 + abort_after && k < 5000) begin @(negedge clk); k++; end
            checks++;
            if (rx_count < rx0 + abort_after) begin
                errors++; $display("FAIL %s_abort_wait got=%0d expected=%0d", name, rx_count - rx0, abort_after);
            end
            rst = 1'b1;
            @(negedge clk);
            checks++;
            if ({lane_rst, phase_base, tx_data, tx_start, busy, done, timeout_flag} !== '0) begin
                errors++;
                $display("FAIL %s_rst_outputs got=%b/%0d/%02h/%b/%b/%b/%b expected=all zero", name,
                         lane_rst, phase_base, tx_data, tx_start, busy, done, timeout_flag);
            end
            rst = 1'b0;
            exp_q.delete();
            return;
        end
        k = 0;
        while (done !== 1'b1 && k < blen * 8 + 500) begin @(negedge clk); k++; end
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL %s_done_wait got=%b expected=1", name, done);
        end
        checks++;
        if (timeout_flag !== exp_flag) begin
            errors++; $display("FAIL %s_timeout_flag got=%b expected=%b", name, timeout_flag, exp_flag);
        end
        checks++;
        if (exp_q.size() != 0 || rx_count - rx0 != 5) begin
            errors++;
            $display("FAIL %s_frame_len got=%0d expected=5", name, rx_count - rx0);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL %s_done_pulse got=done%b/busy%b expected=0/0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; lane_rdy = '0; lane_result = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({lane_rst, phase_base, tx_data, tx_start, busy, done, timeout_flag} !== '0) begin
            errors++; $display("FAIL reset_outputs got=%b/%0d/%02h/%b expected=all zero",
                               lane_rst, phase_base, tx_data, busy);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || lane_rst !== 1'b0) begin
            errors++; $display("FAIL reset_idle got=busy%b/lane_rst%b expected=0/0", busy, lane_rst);
        end
    endtask

    task automatic test_basic();
        g_res = '{'{8'd10, 8'd40, 8'd40, 8'd5}, '{8'd3, 8'd7, 8'd41, 8'd0}};
        g_dly = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}};
        g_xd = -1; g_xv = 8'd0;
        run_sweep("basic", 8, 1'b0, 0);
    endtask

    task automatic test_tie_guard();
        g_res = '{'{8'd9, 8'd9, 8'd9, 8'd9}, '{8'd0, 8'd0, 8'd0, 8'd0}};
        g_dly = '{'{1, 3, 0, 2}, '{0, 1, 2, 3}};
        g_xd = -1; g_xv = 8'd0;
        run_sweep("tie", 0, 1'b0, 0);
    endtask

    task automatic test_timeout();
        g_res = '{'{8'd5, 8'd6, 8'd99, 8'd7}, '{8'd8, 8'd1, 8'd200, 8'd2}};
        g_dly = '{'{0, 2, -1, 4}, '{3, 0, -1, 1}};
        g_xd = -1; g_xv = 8'd0;
        run_sweep("timeout", 4, 1'b0, 0);
    endtask

    task automatic test_first_capture();
        g_res = '{'{8'd50, 8'd20, 8'd30, 8'd45}, '{8'd12, 8'd49, 8'd3, 8'd4}};
        g_dly = '{'{0, 3, 1, 6}, '{2, 5, 0, 1}};
        g_xd = 2; g_xv = 8'd200;
        run_sweep("first_cap", 3, 1'b0, 0);
    endtask

    task automatic test_long_busy();
        g_res = '{'{8'd17, 8'd130, 8'd2, 8'd77}, '{8'd131, 8'd130, 8'd255, 8'd1}};
        g_dly = '{'{2, 0, 1, 0}, '{0, 0, 0, 4}};
        g_xd = -1; g_xv = 8'd0;
        run_sweep("long_busy", 1000, 1'b1, 0);
    endtask

    task automatic test_reset_mid_report();
        g_res = '{'{8'd5, 8'd6, 8'd99, 8'd7}, '{8'd8, 8'd1, 8'd200, 8'd2}};
        g_dly = '{'{0, 2, -1, 4}, '{3, 0, -1, 1}};
        g_xd = -1; g_xv = 8'd0;
        run_sweep("rst_mid", 6, 1'b0, 2);
        repeat (20) @(negedge clk);
        g_res = '{'{8'd60, 8'd61, 8'd62, 8'd63}, '{8'd1, 8'd2, 8'd64, 8'd3}};
        g_dly = '{'{1, 1, 1, 1}, '{0, 2, 1, 0}};
        run_sweep("after_rst", 5, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie_guard();
        test_timeout();
        test_first_capture();
        test_long_busy();
        test_reset_mid_report();
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
